spi_input: RTL and testbench

- SPI receive shift engine, the MISO-side counterpart of spi_output; shares the same sclk and enable.
- Samples miso MSB-first, one bit per sclk rising edge while enable is high.
- Assembles a fixed-length frame (default 5 bytes = 40 bits, the PmodJSTK response length) and presents it on in_bytes with a one-cycle done pulse.
- Sits beside spi_output in the joystick/paddle SPI path; its frame feeds paddle position logic.

---
 rtl/spi_pkg.sv | 14 +
 rtl/jstk_frame_decode.sv | 24 ++
 rtl/spi_input.sv | 146 ++++++++++++++
 tb/tb_spi_input.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, joystick frame constants and receive FSM states
package spi_pkg;

    localparam int SPI_BYTE_W       = 8;
    localparam int JSTK_FRAME_BYTES = 5;
    localparam int JSTK_POS_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/jstk_frame_decode.sv
// rtl/jstk_frame_decode.sv - combinational field extraction from a PmodJSTK response frame
module jstk_frame_decode
    import spi_pkg::*;
(
    input  logic [JSTK_FRAME_BYTES*SPI_BYTE_W-1:0] frame,
    output logic [JSTK_POS_W-1:0]                  x_pos,
    output logic [JSTK_POS_W-1:0]                  y_pos,
    output logic [2:0]                             buttons
);

    // Byte 0 arrives first and sits in the top bits of the frame.
    logic [SPI_BYTE_W-1:0] byte0, byte1, byte2, byte3, byte4;

    assign byte0 = frame[39:32];
    assign byte1 = frame[31:24];
    assign byte2 = frame[23:16];
    assign byte3 = frame[15:8];
    assign byte4 = frame[7:0];

    assign x_pos   = {byte1[1:0], byte0};
    assign y_pos   = {byte3[1:0], byte2};
    assign buttons = byte4[2:0];

endmodule

// File: rtl/spi_input.sv
// rtl/spi_input.sv - SPI MISO receive shift engine; optional decode via SPI_INPUT_JSTK_DECODE_EN
module spi_input
    import spi_pkg::*;
#(
    parameter int NUM_BYTES = 5
)(
    input  logic                             sclk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             miso,
    output logic [NUM_BYTES*SPI_BYTE_W-1:0]  in_bytes,
    output logic                             done,
    output logic                             byte_strobe,
    output logic [SPI_BYTE_W-1:0]            last_byte,
    output logic                             busy
`ifdef SPI_INPUT_JSTK_DECODE_EN
    ,
    output logic [JSTK_POS_W-1:0]            x_pos,
    output logic [JSTK_POS_W-1:0]            y_pos,
    output logic [2:0]                       buttons
`endif
);

    localparam int FW = NUM_BYTES * SPI_BYTE_W;
    localparam int CW = $clog2(FW + 1);

    spi_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         shift_q, shift_d;
    logic [FW-1:0]         in_bytes_q, in_bytes_d;
    logic [SPI_BYTE_W-1:0] last_byte_q, last_byte_d;
    logic                  done_q, done_d;
    logic                  strobe_q, strobe_d;

    // Next-state logic: sample on every enabled edge, abort a partial frame when enable drops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        in_bytes_d  = in_bytes_q;
        last_byte_d = last_byte_q;
        done_d      = 1'b0;
        strobe_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    // First bit is captured on the very first enabled edge.
                    shift_d = {{(FW-1){1'b0}}, miso};
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    shift_d = {shift_q[FW-2:0], miso};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_d[2:0] == 3'd0) begin
                        strobe_d    = 1'b1;
                        last_byte_d = shift_d[SPI_BYTE_W-1:0];
                    end
                    if (cnt_d == CW'(FW)) begin
                        in_bytes_d = shift_d;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                // Extra enabled edges are ignored until enable goes low.
                if (!enable) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            in_bytes_q  <= '0;
            last_byte_q <= '0;
            done_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            in_bytes_q  <= in_bytes_d;
            last_byte_q <= last_byte_d;
            done_q      <= done_d;
            strobe_q    <= strobe_d;
        end
    end

    assign in_bytes    = in_bytes_q;
    assign done        = done_q;
    assign byte_strobe = strobe_q;
    assign last_byte   = last_byte_q;
    assign busy        = (state_q == ST_SHIFT);

`ifdef SPI_INPUT_JSTK_DECODE_EN
    if (NUM_BYTES != JSTK_FRAME_BYTES) begin : g_bad_len
        $error("spi_input: joystick decode needs NUM_BYTES == %0d", JSTK_FRAME_BYTES);
    end

    logic [JSTK_POS_W-1:0] x_pos_d, y_pos_d, x_pos_q, y_pos_q;
    logic [2:0]            buttons_d, buttons_q;

    jstk_frame_decode u_decode (
        .frame   (shift_d),
        .x_pos   (x_pos_d),
        .y_pos   (y_pos_d),
        .buttons (buttons_d)
    );

    // Decoded fields load together with in_bytes so they always describe the same frame.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            x_pos_q   <= '0;
            y_pos_q   <= '0;
            buttons_q <= '0;
        end else if (done_d) begin
            x_pos_q   <= x_pos_d;
            y_pos_q   <= y_pos_d;
            buttons_q <= buttons_d;
        end
    end

    assign x_pos   = x_pos_q;
    assign y_pos   = y_pos_q;
    assign buttons = buttons_q;
`endif

endmodule

// File: tb/tb_spi_input.sv
// tb/tb_spi_input.sv - randomized self-checking bench for spi_input
module tb_spi_input;

    localparam int FW = 40;

    logic          sclk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          miso = 1'b0;
    logic [FW-1:0] in_bytes;
    logic          done;
    logic          byte_strobe;
    logic [7:0]    last_byte;
    logic          busy;
`ifdef SPI_INPUT_JSTK_DECODE_EN
    logic [9:0]    x_pos;
    logic [9:0]    y_pos;
    logic [2:0]    buttons;
`endif

    int total = 0;
    int bad = 0;

    int          step_idx;
    int          done_cnt;
    int          done_at;
    logic [7:0]  strobe_log[$];
    logic [FW-1:0] exp_in_bytes;

    spi_input #(.NUM_BYTES(5)) dut (
        .sclk        (sclk),
        .reset       (reset),
        .enable      (enable),
        .miso        (miso),
        .in_bytes    (in_bytes),
        .done        (done),
        .byte_strobe (byte_strobe),
        .last_byte   (last_byte),
        .busy        (busy)
`ifdef SPI_INPUT_JSTK_DECODE_EN
        ,
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .buttons     (buttons)
`endif
    );

    always #5 sclk = ~sclk;

    // Reference: byte k of a frame (k=0 is the first byte on the wire).
    function automatic logic [7:0] frame_byte(input logic [FW-1:0] f, input int k);
        logic [FW-1:0] t;
        t = f >> (8 * (4 - k));
        return t[7:0];
    endfunction

    task automatic clear_mon();
        step_idx = 0;
        done_cnt = 0;
        done_at  = -1;
        strobe_log.delete();
    endtask

    // One sclk edge: drive at the falling edge, observe 1 time unit after the rising edge.
    task automatic step(input logic en, input logic b);
        @(negedge sclk);
        enable = en;
        miso   = b;
        @(posedge sclk);
        #1;
        step_idx++;
        if (done === 1'b1) begin
            done_cnt++;
            done_at = step_idx;
        end
        if (byte_strobe === 1'b1) strobe_log.push_back(last_byte);
    endtask

    task automatic send_bits(input logic [FW-1:0] f, input int n);
        for (int i = 0; i < n; i++) step(1'b1, f[FW-1-i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++; if (in_bytes !== '0) begin bad++; $display("FAIL reset_in_bytes got=%h exp=0", in_bytes); end
        total++; if (last_byte !== 8'h0) begin bad++; $display("FAIL reset_last_byte got=%h exp=0", last_byte); end
        total++; if ({done, byte_strobe, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {done, byte_strobe, busy}); end
        @(negedge sclk);
        reset = 1'b0;
        exp_in_bytes = '0;
    endtask

    task automatic test_basic_frame();
        logic [FW-1:0] f;
        f = 40'h8B9BABCBEB;
        clear_mon();
        step(1'b0, 1'b0);
        clear_mon();
        step(1'b1, f[FW-1]);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 1; i < FW; i++) step(1'b1, f[FW-1-i]);
        exp_in_bytes = f;
        total++; if (in_bytes !== exp_in_bytes) begin bad++; $display("FAIL basic_in_bytes got=%h exp=%h", in_bytes, exp_in_bytes); end
        total++; if (done_cnt !== 1 || done_at !== FW) begin bad++; $display("FAIL basic_done got=%0d@%0d exp=1@%0d", done_cnt, done_at, FW); end
        total++; if (strobe_log.size() !== 5) begin bad++; $display("FAIL basic_strobes got=%0d exp=5", strobe_log.size()); end
        for (int k = 0; k < 5 && k < strobe_log.size(); k++) begin
            total++;
            if (strobe_log[k] !== frame_byte(f, k)) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", k, strobe_log[k], frame_byte(f, k)); end
        end
        // Pulse width: the flag must drop on the next edge.
        step(1'b1, 1'b1);
        total++; if (done !== 1'b0 || byte_strobe !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b%b exp=00", done, byte_strobe); end
    endtask

    task automatic test_hold_done();
        clear_mon();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        total++; if (in_bytes !== exp_in_bytes) begin bad++; $display("FAIL hold_in_bytes got=%h exp=%h", in_bytes, exp_in_bytes); end
        total++; if (done_cnt !== 0 || strobe_log.size() !== 0) begin bad++; $display("FAIL hold_pulses got=%0d/%0d exp=0/0", done_cnt, strobe_log.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%b exp=0", busy); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [FW-1:0] f2;
        clear_mon();
        send_bits(40'h0102030405, FW);
        exp_in_bytes = 40'h0102030405;
        step(1'b0, 1'b0);
        f2 = {8'($urandom), 32'($urandom)};
        clear_mon();
        send_bits(f2, 12);
        step(1'b0, 1'b1);
        total++; if (in_bytes !== exp_in_bytes) begin bad++; $display("FAIL abort_in_bytes got=%h exp=%h", in_bytes, exp_in_bytes); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        total++; if (strobe_log.size() !== 1) begin bad++; $display("FAIL abort_strobes got=%0d exp=1", strobe_log.size()); end
        else begin
            total++; if (strobe_log[0] !== frame_byte(f2, 0)) begin bad++; $display("FAIL abort_byte got=%h exp=%h", strobe_log[0], frame_byte(f2, 0)); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random_abort();
        logic [FW-1:0] f;
        int n;
        for (int r = 0; r < 6; r++) begin
            f = {8'($urandom), 32'($urandom)};
            n = $urandom_range(1, FW - 1);
            clear_mon();
            send_bits(f, n);
            step(1'b0, 1'b0);
            total++; if (done_cnt !== 0 || in_bytes !== exp_in_bytes) begin bad++; $display("FAIL rabort_n%0d got=%0d/%h exp=0/%h", n, done_cnt, in_bytes, exp_in_bytes); end
            total++; if (strobe_log.size() !== n / 8) begin bad++; $display("FAIL rabort_strobes_n%0d got=%0d exp=%0d", n, strobe_log.size(), n / 8); end
            for (int k = 0; k < strobe_log.size() && k < n / 8; k++) begin
                total++;
                if (strobe_log[k] !== frame_byte(f, k)) begin bad++; $display("FAIL rabort_byte%0d got=%h exp=%h", k, strobe_log[k], frame_byte(f, k)); end
            end
        end
    endtask

    task automatic test_async_reset();
        clear_mon();
        send_bits({8'($urandom), 32'($urandom)}, 20);
        #2;
        reset = 1'b1;
        #1;
        total++; if (in_bytes !== '0 || last_byte !== 8'h0) begin bad++; $display("FAIL areset_data got=%h/%h exp=0/0", in_bytes, last_byte); end
        total++; if ({done, byte_strobe, busy} !== 3'b000) begin bad++; $display("FAIL areset_flags got=%b exp=000", {done, byte_strobe, busy}); end
        @(negedge sclk);
        reset = 1'b0;
        exp_in_bytes = '0;
        step(1'b0, 1'b0);
        clear_mon();
        send_bits({FW{1'b1}}, FW);
        exp_in_bytes = {FW{1'b1}};
        total++; if (in_bytes !== exp_in_bytes || done_cnt !== 1) begin bad++; $display("FAIL areset_next got=%h/%0d exp=%h/1", in_bytes, done_cnt, exp_in_bytes); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] f;
        for (int r = 0; r < 4; r++) begin
            f = {8'($urandom), 32'($urandom)};
            clear_mon();
            send_bits(f, FW);
            exp_in_bytes = f;
            total++; if (in_bytes !== exp_in_bytes || done_cnt !== 1 || done_at !== FW) begin bad++; $display("FAIL b2b_%0d got=%h/%0d@%0d exp=%h/1@%0d", r, in_bytes, done_cnt, done_at, exp_in_bytes, FW); end
            total++; if (strobe_log.size() !== 5 || strobe_log[4] !== frame_byte(f, 4)) begin bad++; $display("FAIL b2b_strobes_%0d got=%0d exp=5", r, strobe_log.size()); end
            step(1'b0, 1'b0);
        end
    endtask

`ifdef SPI_INPUT_JSTK_DECODE_EN
    task automatic test_jstk();
        clear_mon();
        send_bits(40'hFF02800105, FW);
        total++; if (x_pos !== 10'h2FF) begin bad++; $display("FAIL jstk_x got=%h exp=2ff", x_pos); end
        total++; if (y_pos !== 10'h180) begin bad++; $display("FAIL jstk_y got=%h exp=180", y_pos); end
        total++; if (buttons !== 3'b101) begin bad++; $display("FAIL jstk_buttons got=%b exp=101", buttons); end
        step(1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_done();
        test_abort();
        test_random_abort();
        test_async_reset();
        test_back_to_back();
`ifdef SPI_INPUT_JSTK_DECODE_EN
        test_jstk();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
